// File: rtl/jtag_debug_scan_master.sv
// Host-side virtual-JTAG scan initiator: turns a parallel IR/DR command into a
// TCK-framed UIR, CDR, SDR, UDR sequence and returns the captured TDO bits.
module jtag_debug_scan_master #(
   parameter int IR_W     = 2,
   parameter int DR_LEN   = 38,
   parameter int TCK_HALF = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [IR_W-1:0]   cmd_ir,
   input  logic [DR_LEN-1:0] cmd_dr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DR_LEN-1:0] rsp_dr,
   output logic              busy,
   output logic              vji_tck,
   output logic              vji_tdi,
   input  logic              vji_tdo,
   output logic [IR_W-1:0]   vji_ir_in,
   output logic              vji_rti,
   output logic              vji_uir,
   output logic              vji_cdr,
   output logic              vji_sdr,
   output logic              vji_udr
);

   localparam int              CNT_W    = $clog2(DR_LEN + 1);
   localparam logic [7:0]       DIV_LAST = 8'(TCK_HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UIR,
      S_CDR,
      S_SDR,
      S_UDR,
      S_RESP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        div_cnt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DR_LEN-1:0] shift_reg;
   logic [DR_LEN-1:0] capture_reg;
   logic              scanning;
   logic              tick;
   logic              rise_tick;
   logic              fall_tick;
   logic              accept;

   // Every scan state ends on a falling tick, so TCK is always low between states.
   always_comb begin
      scanning  = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) || (state == S_UDR);
      tick      = scanning && (div_cnt == DIV_LAST);
      rise_tick = tick && !vji_tck;
      fall_tick = tick && vji_tck;
      accept    = (state == S_IDLE) && cmd_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = scanning;
      vji_rti   = 1'b0;
      vji_uir   = 1'b0;
      vji_cdr   = 1'b0;
      vji_sdr   = 1'b0;
      vji_udr   = 1'b0;
      vji_tdi   = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            vji_rti   = 1'b1;
            if (cmd_valid) begin
               state_nxt = S_UIR;
            end
         end
         S_UIR: begin
            vji_uir = 1'b1;
            if (fall_tick) begin
               state_nxt = S_CDR;
            end
         end
         S_CDR: begin
            vji_cdr = 1'b1;
            if (fall_tick) begin
               state_nxt = S_SDR;
            end
         end
         S_SDR: begin
            vji_sdr = 1'b1;
            vji_tdi = shift_reg[0];
            if (fall_tick && (bit_cnt == BIT_LAST)) begin
               state_nxt = S_UDR;
            end
         end
         S_UDR: begin
            vji_udr = 1'b1;
            if (fall_tick) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Data is sampled on the rising tick and the next bit is presented after the falling tick.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt     <= '0;
         bit_cnt     <= '0;
         vji_tck     <= 1'b0;
         vji_ir_in   <= '0;
         shift_reg   <= '0;
         capture_reg <= '0;
         rsp_dr      <= '0;
      end else if (accept) begin
         div_cnt     <= '0;
         bit_cnt     <= '0;
         vji_tck     <= 1'b0;
         vji_ir_in   <= cmd_ir;
         shift_reg   <= cmd_dr;
         capture_reg <= '0;
      end else if (scanning) begin
         if (tick) begin
            div_cnt <= '0;
            vji_tck <= ~vji_tck;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         if (rise_tick && (state == S_SDR)) begin
            capture_reg <= {vji_tdo, capture_reg[DR_LEN-1:1]};
         end
         if (fall_tick && (state == S_SDR)) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
         end
         if (fall_tick && (state == S_UDR)) begin
            rsp_dr <= capture_reg;
         end
      end else begin
         div_cnt <= '0;
         vji_tck <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Randomized scoreboard bench for jtag_debug_scan_master: a target model drives TDO,
// a monitor checks every response against expectations queued at command issue.
module tb_jtag_debug_scan_master;

   localparam int DR_LEN = 38;
   localparam int IR_W   = 2;
   localparam int LAT0   = (DR_LEN + 3) * 2 * 2;
   localparam int LAT1   = (DR_LEN + 3) * 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic              cmd_valid, cmd_ready;
   logic [IR_W-1:0]   cmd_ir;
   logic [DR_LEN-1:0] cmd_dr;
   logic              rsp_valid, rsp_ready;
   logic [DR_LEN-1:0] rsp_dr;
   logic              busy, vji_tck, vji_tdi, vji_tdo;
   logic [IR_W-1:0]   vji_ir_in;
   logic              vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

   logic              h1_cmd_valid, h1_cmd_ready;
   logic [IR_W-1:0]   h1_cmd_ir;
   logic [DR_LEN-1:0] h1_cmd_dr;
   logic              h1_rsp_valid, h1_rsp_ready;
   logic [DR_LEN-1:0] h1_rsp_dr;
   logic              h1_busy, h1_vji_tck, h1_vji_tdi, h1_vji_tdo;
   logic [IR_W-1:0]   h1_vji_ir_in;
   logic              h1_vji_rti, h1_vji_uir, h1_vji_cdr, h1_vji_sdr, h1_vji_udr;

   jtag_debug_scan_master #(.IR_W(IR_W), .DR_LEN(DR_LEN), .TCK_HALF(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .busy(busy),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
      .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr)
   );

   jtag_debug_scan_master #(.IR_W(IR_W), .DR_LEN(DR_LEN), .TCK_HALF(1)) dut_half1 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(h1_cmd_valid), .cmd_ready(h1_cmd_ready), .cmd_ir(h1_cmd_ir), .cmd_dr(h1_cmd_dr),
      .rsp_valid(h1_rsp_valid), .rsp_ready(h1_rsp_ready), .rsp_dr(h1_rsp_dr), .busy(h1_busy),
      .vji_tck(h1_vji_tck), .vji_tdi(h1_vji_tdi), .vji_tdo(h1_vji_tdo), .vji_ir_in(h1_vji_ir_in),
      .vji_rti(h1_vji_rti), .vji_uir(h1_vji_uir), .vji_cdr(h1_vji_cdr), .vji_sdr(h1_vji_sdr),
      .vji_udr(h1_vji_udr)
   );

   assign h1_vji_tdo = h1_vji_tdi;

   typedef struct {
      logic [DR_LEN-1:0] rsp;
      logic [DR_LEN-1:0] tdi;
      logic [IR_W-1:0]   ir;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int accept_cyc = 0;
   int rdy_mode;
   bit mon_en   = 1'b0;
   logic rsp_valid_q = 1'b0;

   // Target model: tdo mode 0 loopback, 1 tied low, 2 tied high, 3 fixed data register.
   int                tdo_mode = 0;
   logic [DR_LEN-1:0] tgt_sr   = '0;
   logic [5:0]        tgt_idx  = '0;
   bit                shift_pend = 1'b0;
   logic [DR_LEN-1:0] rx_bits  = '0;
   logic [5:0]        rx_cnt   = '0;
   int cnt_uir = 0, cnt_cdr = 0, cnt_sdr = 0, cnt_udr = 0;

   assign vji_tdo = (tdo_mode == 0) ? vji_tdi :
                    (tdo_mode == 1) ? 1'b0 :
                    (tdo_mode == 2) ? 1'b1 :
                    ((tgt_idx < 6'd38) ? tgt_sr[tgt_idx] : 1'b0);

   always @(posedge vji_tck) begin
      if (vji_cdr) tgt_idx = '0;
      if (vji_sdr) begin
         shift_pend = 1'b1;
         if (rx_cnt < 6'd38) rx_bits[rx_cnt] = vji_tdi;
         rx_cnt = rx_cnt + 6'd1;
      end
      cnt_uir += int'(vji_uir);
      cnt_cdr += int'(vji_cdr);
      cnt_sdr += int'(vji_sdr);
      cnt_udr += int'(vji_udr);
   end

   always @(negedge vji_tck) begin
      if (shift_pend) begin
         shift_pend = 1'b0;
         tgt_idx = tgt_idx + 6'd1;
      end
   end

   always @(posedge clk) cyc++;

   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   // Monitor: tracks accepts, checks framing each cycle and pops the scoreboard on each response.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cmd_valid && cmd_ready) begin
            accept_cyc = cyc + 1;
            rx_cnt = '0;
            rx_bits = '0;
            cnt_uir = 0; cnt_cdr = 0; cnt_sdr = 0; cnt_udr = 0;
         end
         checkOutput("indicator_onehot", 64'($countones({vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr})),
                     rsp_valid ? 64'd0 : 64'd1);
         if (!busy) checkOutput("tck_low_when_idle", 64'(vji_tck), 64'd0);
         if (rsp_valid && !rsp_valid_q) checkOutput("rsp_latency", 64'(cyc - accept_cyc), 64'(LAT0));
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("rsp_dr", 64'(rsp_dr), 64'(e.rsp));
               checkOutput("tdi_stream", 64'(rx_bits), 64'(e.tdi));
               checkOutput("ir_in", 64'(vji_ir_in), 64'(e.ir));
               checkOutput("uir_periods", 64'(cnt_uir), 64'd1);
               checkOutput("cdr_periods", 64'(cnt_cdr), 64'd1);
               checkOutput("sdr_periods", 64'(cnt_sdr), 64'(DR_LEN));
               checkOutput("udr_periods", 64'(cnt_udr), 64'd1);
            end
         end
         rsp_valid_q = rsp_valid;
      end
   end

   task automatic waitIdle();
      int n = 0;
      while (!cmd_ready && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      if (!cmd_ready) checkOutput("idle_timeout", 64'(cmd_ready), 64'd1);
   endtask

   task automatic applyStimulus(input logic [IR_W-1:0] ir, input logic [DR_LEN-1:0] dr,
                                input int mode, input logic [DR_LEN-1:0] sr);
      exp_t e;
      waitIdle();
      tdo_mode = mode;
      tgt_sr   = sr;
      case (mode)
         0:       e.rsp = dr;
         1:       e.rsp = '0;
         2:       e.rsp = {DR_LEN{1'b1}};
         default: e.rsp = sr;
      endcase
      e.tdi = dr;
      e.ir  = ir;
      sb.push_back(e);
      cmd_ir    = ir;
      cmd_dr    = dr;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_ir    = 2'($urandom);
      cmd_dr    = {6'($urandom), $urandom};
   endtask

   // TCK_HALF=1 instance: back-to-back loopback scans, latency and TCK pattern.
   task automatic runHalfOne();
      for (int k = 0; k < 4; k++) begin
         logic [DR_LEN-1:0] d;
         int n, terr;
         d = {6'($urandom), $urandom};
         n = 0;
         while (!h1_cmd_ready && n < 300) begin
            @(posedge clk); #1; n++;
         end
         checkOutput("h1_ready", 64'(h1_cmd_ready), 64'd1);
         h1_cmd_dr = d;
         h1_cmd_ir = 2'($urandom);
         h1_cmd_valid = 1'b1;
         @(posedge clk); #1;
         h1_cmd_valid = 1'b0;
         n = 0;
         terr = 0;
         while (!h1_rsp_valid && n < 300) begin
            @(posedge clk); #1; n++;
            if (h1_vji_tck !== 1'(n & 1)) terr++;
         end
         checkOutput("h1_latency", 64'(n), 64'(LAT1));
         checkOutput("h1_tck_pattern", 64'(terr), 64'd0);
         checkOutput("h1_rsp_dr", 64'(h1_rsp_dr), 64'(d));
      end
   endtask

   initial begin
      int n;
      bit seen;
      logic [DR_LEN-1:0] snap;
      exp_t e;
      reset_n = 1'b0;
      rdy_mode = 2;
      cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0;
      h1_cmd_valid = 1'b0; h1_cmd_ir = '0; h1_cmd_dr = '0; h1_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_rsp_dr", 64'(rsp_dr), 64'd0);
      checkOutput("reset_jtag_pins", 64'({vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr}),
                  64'(9'b000010000));
      reset_n = 1'b1;
      mon_en = 1'b1;

      runHalfOne();

      $display("[TB] directed scans");
      applyStimulus(2'b01, 38'h2A_5A5A_5A5A, 0, '0);
      applyStimulus(2'b10, 38'h15_0F0F_1234, 2, '0);
      applyStimulus(2'b11, 38'h3F_FFFF_FFFF, 1, '0);
      applyStimulus(2'b00, 38'h00_DEAD_BEEF, 3, 38'h01_2345_6789);

      $display("[TB] response backpressure");
      waitIdle();
      rdy_mode = 1;
      applyStimulus(2'b10, {6'($urandom), $urandom}, 0, '0);
      n = 0;
      while (!rsp_valid && n < 400) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      snap      = rsp_dr;
      e.tdi     = 38'h0A_BCDE_F012;
      e.rsp     = e.tdi;
      e.ir      = 2'b11;
      cmd_ir    = e.ir;
      cmd_dr    = e.tdi;
      cmd_valid = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         checkOutput("bp_rsp_dr_stable", 64'(rsp_dr), 64'(snap));
         checkOutput("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
         checkOutput("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
      end
      sb.push_back(e);
      rdy_mode = 2;
      @(posedge clk); #1;
      checkOutput("bp_idle_after_handshake", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
      @(posedge clk); #1;
      checkOutput("bp_second_accepted", 64'({busy, cmd_ready}), 64'(2'b10));
      cmd_valid = 1'b0;

      $display("[TB] reset during shift");
      applyStimulus(2'b01, {6'($urandom), $urandom}, 0, '0);
      n = 0;
      while (rx_cnt < 6'd10 && n < 500) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("abort_in_sdr", 64'(vji_sdr), 64'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      sb.delete();
      checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("abort_tck", 64'(vji_tck), 64'd0);
      checkOutput("abort_rti", 64'(vji_rti), 64'd1);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (200) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      checkOutput("abort_no_rsp", 64'(seen), 64'd0);
      applyStimulus(2'b10, 38'h12_3456_789A, 0, '0);

      $display("[TB] random scans");
      rdy_mode = 0;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(2'($urandom), {6'($urandom), $urandom}, int'($urandom_range(0, 3)),
                       {6'($urandom), $urandom});
      end
      rdy_mode = 2;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
